alu_mc: RTL and testbench

- Parametrised multicycle successor to the single-cycle datapath ALU. Same function codes and operand encodings.
- Multiply and divide run as iterative engines instead of combinational arrays, so wide datapaths close timing.
- Sits between the register-file read stage and writeback of the multicycle processor. The control FSM issues `i_start` and waits for `o_done`.

---
 rtl/alu_mc.sv | 208 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU with iterative multiply and divide engines.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   i_start     : operation request, accepted only while idle
//   func        : operation code
//   shiftamt    : shift count for the shift operations
//   a, b        : operands, captured when the request is accepted
//   o_data      : result, held until the next accepted request finishes
//   o_done      : one-cycle pulse when o_data and the flags are valid
//   o_busy      : high while an accepted operation is in progress
//   o_ovf       : magnitude overflow (sign-magnitude add / multiply)
//   o_dz        : divide by zero
//   o_illegal   : unsupported operation code
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [5:0]       func,
  input  logic [SHW-1:0]   shiftamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o_data,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_ovf,
  output logic             o_dz,
  output logic             o_illegal
);

  localparam int MW = WIDTH - 1;  // magnitude width of sign-magnitude operands

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [5:0]           func_q, func_d;
  logic [SHW-1:0]       sh_q, sh_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*MW-1:0]      prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 done_q, done_d, ovf_q, ovf_d, dz_q, dz_d, ill_q, ill_d;

  // Sign-magnitude addition; returns {overflow, result}.
  function automatic logic [WIDTH:0] sm_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [MW-1:0] mx, my, mag;
    logic [MW:0]   sum;
    logic          sgn;
    mx  = x[MW-1:0];
    my  = y[MW-1:0];
    sum = {1'b0, mx} + {1'b0, my};
    mag = '0;
    sgn = 1'b0;
    if (x[WIDTH-1] == y[WIDTH-1]) begin
      mag = sum[MW-1:0];
      sgn = x[WIDTH-1];
    end else if (mx >= my) begin
      mag = mx - my;
      sgn = x[WIDTH-1] & (|mag);  // equal magnitudes give +0
    end else begin
      mag = my - mx;
      sgn = y[WIDTH-1];
    end
    return {(x[WIDTH-1] == y[WIDTH-1]) & sum[MW], sgn, mag};
  endfunction

  logic [MW:0]          mul_sum;
  logic [WIDTH:0]       rem_sh, trial;
  logic [WIDTH:0]       add_res;
  logic [MW-1:0]        mul_mag;
  logic signed [WIDTH-1:0] sub_res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    sh_d    = sh_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    ill_d   = ill_q;

    // Shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole product/multiplier register right by one.
    mul_sum = {1'b0, prod_q[2*MW-1:MW]} + (prod_q[0] ? {1'b0, a_q[MW-1:0]} : '0);

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    // trial[WIDTH] is the borrow, so a clear MSB means rem_sh >= b.
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, b_q};

    add_res = sm_add(a_q, b_q);
    mul_mag = prod_q[MW-1:0];
    sub_res = $signed(a_q) - $signed(b_q);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          func_d = func;
          sh_d   = shiftamt;
          a_d    = a;
          b_d    = b;
          cnt_d  = '0;
          prod_d = {{MW{1'b0}}, b[MW-1:0]};
          rem_d  = '0;
          quo_d  = a;
          if (func == 6'd3)                  state_d = S_MUL;
          else if (func == 6'd2 && b != '0)  state_d = S_DIV;
          else                               state_d = S_FIN;
        end
      end
      S_MUL: begin
        prod_d = {mul_sum, prod_q[MW-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-2)) state_d = S_FIN;
      end
      S_DIV: begin
        if (!trial[WIDTH]) rem_d = trial[WIDTH-1:0];
        else               rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        dz_d    = 1'b0;
        ill_d   = 1'b0;
        case (func_q)
          6'd0: begin
            data_d = add_res[WIDTH-1:0];
            ovf_d  = add_res[WIDTH];
          end
          6'd1: data_d = sub_res;
          6'd2: begin
            if (b_q == '0) begin
              data_d = '1;
              dz_d   = 1'b1;
            end else begin
              data_d = quo_q;
            end
          end
          6'd3: begin
            data_d = {(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (|mul_mag), mul_mag};
            ovf_d  = |prod_q[2*MW-1:MW];
          end
          6'd4: data_d = b_q >> sh_q;
          6'd5: data_d = b_q << sh_q;
          6'd6: data_d = a_q >> sh_q;
          6'd7: data_d = a_q << sh_q;
          default: begin
            data_d = '0;
            ill_d  = 1'b1;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  // Operand and engine registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    func_q <= func_d;
    sh_q   <= sh_d;
    a_q    <= a_d;
    b_q    <= b_d;
    prod_q <= prod_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
  end

  assign o_data    = data_q;
  assign o_done    = done_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_ovf     = ovf_q;
  assign o_dz      = dz_q;
  assign o_illegal = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH=32) with directed vectors.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [5:0]  func = '0;
  logic [4:0]  shiftamt = '0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] o_data;
  logic        o_done, o_busy, o_ovf, o_dz, o_illegal;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .func(func), .shiftamt(shiftamt),
    .a(a), .b(b), .o_data(o_data), .o_done(o_done), .o_busy(o_busy),
    .o_ovf(o_ovf), .o_dz(o_dz), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        ovf, dz, ill;
    int          due;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] av, bv, data;
    logic        ovf, dz, ill;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0, n_done = 0, n_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, o_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, o_data, e.data);
        chk({e.name, "_ovf"}, {31'd0, o_ovf}, {31'd0, e.ovf});
        chk({e.name, "_dz"}, {31'd0, o_dz}, {31'd0, e.dz});
        chk({e.name, "_ill"}, {31'd0, o_illegal}, {31'd0, e.ill});
        chk({e.name, "_cycle"}, cyc, e.due);
      end
    end
  end

  // Issue one request (called at a negedge), push its expectation and wait
  // for done. If glitch >= 0, a second start with other operands is pulsed
  // that many negedges into the operation.
  task automatic issue(input vec_t v, input int glitch, output int busy_n);
    exp_t e;
    int n;
    e.name = v.name; e.data = v.data; e.ovf = v.ovf; e.dz = v.dz; e.ill = v.ill;
    e.due  = cyc + 1 + v.lat;
    sb.push_back(e);
    n_exp++;
    func = v.f; shiftamt = v.sh; a = v.av; b = v.bv; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0; busy_n = 0;
    while (!o_done && n < 80) begin
      if (o_busy) busy_n++;
      if (n == glitch) begin
        i_start = 1'b1; func = 6'd0; a = 32'h0000_0001; b = 32'h0000_0001;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
    if (!o_done) chk({v.name, "_timeout"}, {31'd0, o_done}, 32'd1);
  endtask

  vec_t vecs [12];
  vec_t v;
  int   busy_n;

  initial begin
    vecs[0]  = '{"add_diff",   6'd0, 5'd0,  32'h0000_0005, 32'h8000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{"add_zero",   6'd0, 5'd0,  32'h0000_0005, 32'h8000_0005, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{"add_ovf",    6'd0, 5'd0,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFE, 1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{"add_negbig", 6'd0, 5'd0,  32'h0000_0003, 32'h8000_0005, 32'h8000_0002, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{"sub",        6'd1, 5'd0,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{"shl_b",      6'd5, 5'd31, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{"shr_a",      6'd6, 5'd4,  32'h8000_0000, 32'h0000_0000, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{"shr_b",      6'd4, 5'd4,  32'h0000_0000, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{"shl_a",      6'd7, 5'd1,  32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{"illegal",    6'd9, 5'd0,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{"mul_ovf",    6'd3, 5'd0,  32'h4000_0000, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32};
    vecs[11] = '{"div_zero",   6'd2, 5'd0,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1};

    repeat (3) @(negedge clk);
    chk("rst_data", o_data, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_flags", {29'd0, o_ovf, o_dz, o_illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each next start is driven at the negedge done is seen.
    foreach (vecs[i]) issue(vecs[i], -1, busy_n);

    v = '{"mul", 6'd3, 5'd0, 32'h8000_0006, 32'h0000_0007, 32'h8000_002A, 1'b0, 1'b0, 1'b0, 32};
    issue(v, -1, busy_n);
    chk("mul_busy_cycles", busy_n, 32);

    v = '{"div", 6'd2, 5'd0, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 33};
    issue(v, -1, busy_n);
    chk("div_busy_cycles", busy_n, 33);

    // Start pulse with new operands during a divide must be ignored.
    v.name = "div_ignore";
    issue(v, 4, busy_n);
    repeat (5) @(negedge clk);

    // Reset in the middle of a multiply.
    func = 6'd3; a = 32'h0000_0003; b = 32'h0000_0005; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_data", o_data, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_done", {31'd0, o_done}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    v = '{"add_after_rst", 6'd0, 5'd0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1};
    issue(v, -1, busy_n);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("done_count", n_done, n_exp);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
